mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM pipeline register with byte-addressable data memory
//
// Ports:
//    Clock             rising-edge clock for all state
//    Reset             active-low, asynchronous assertion; clears the EX/MEM register only
//    Stall             hold the EX/MEM register contents
//    Flush             load a bubble into the EX/MEM register (wins over Stall)
//    EX_ALUResult      byte address or ALU result from EX
//    EX_StoreData      forwarded rt value for stores
//    EX_RegDest        destination register
//    EX_RegWrite       register-write enable
//    EX_MemRead        load request
//    EX_MemWrite       store request
//    EX_MemSize        00 word, 01 half, 10 byte, 11 treated as word
//    EX_LoadUnsigned   zero-extend sub-word loads
//    MEM_ALUResult     latched ALU result (forwarding source)
//    MEM_ReadData      extended load data (forwarding source)
//    MEM_RegDest       latched destination register
//    MEM_RegWrite      latched RegWrite, dropped for misaligned loads
//    MEM_MemRead       latched MemRead
//    MEM_Misaligned    current entry is a misaligned memory access

module mem_stage #(
   parameter int ADDR_W = 8
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic [31:0] EX_ALUResult,
   input  logic [31:0] EX_StoreData,
   input  logic [4:0]  EX_RegDest,
   input  logic        EX_RegWrite,
   input  logic        EX_MemRead,
   input  logic        EX_MemWrite,
   input  logic [1:0]  EX_MemSize,
   input  logic        EX_LoadUnsigned,
   output logic [31:0] MEM_ALUResult,
   output logic [31:0] MEM_ReadData,
   output logic [4:0]  MEM_RegDest,
   output logic        MEM_RegWrite,
   output logic        MEM_MemRead,
   output logic        MEM_Misaligned
);

   localparam int DEPTH = 1 << ADDR_W;

   // EX/MEM register
   logic [31:0] alu_q;
   logic [31:0] store_q;
   logic [4:0]  dest_q;
   logic        reg_write_q;
   logic        mem_read_q;
   logic        mem_write_q;
   logic [1:0]  size_q;
   logic        unsigned_q;

   // Zero initial contents; reset never touches the array.
   logic [31:0] mem [DEPTH] = '{default: '0};

   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       mem_word;
   logic              is_byte;
   logic              is_half;
   logic              is_word;
   logic              misaligned;
   logic [3:0]        lane_en;
   logic [31:0]       lane_data;
   logic [7:0]        byte_val;
   logic [15:0]       half_val;
   logic [31:0]       load_val;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         alu_q       <= '0;
         store_q     <= '0;
         dest_q      <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         size_q      <= '0;
         unsigned_q  <= 1'b0;
      end else if (Flush) begin
         // A bubble is an all-zero entry, so no control can leak through.
         alu_q       <= '0;
         store_q     <= '0;
         dest_q      <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         size_q      <= '0;
         unsigned_q  <= 1'b0;
      end else if (!Stall) begin
         alu_q       <= EX_ALUResult;
         store_q     <= EX_StoreData;
         dest_q      <= EX_RegDest;
         reg_write_q <= EX_RegWrite;
         mem_read_q  <= EX_MemRead;
         mem_write_q <= EX_MemWrite;
         size_q      <= EX_MemSize;
         unsigned_q  <= EX_LoadUnsigned;
      end
   end

   // Upper address bits are dropped, so addresses wrap modulo the array size.
   assign word_idx = alu_q[ADDR_W+1:2];
   assign mem_word = mem[word_idx];

   assign is_byte = (size_q == 2'b10);
   assign is_half = (size_q == 2'b01);
   assign is_word = !is_byte && !is_half;

   assign misaligned = (mem_read_q || mem_write_q) &&
                       ((is_half && alu_q[0]) || (is_word && (alu_q[1:0] != 2'b00)));

   // Store lanes: data is replicated so the selected lane always holds the low byte/half.
   always_comb begin
      lane_en   = 4'b0000;
      lane_data = store_q;
      if (is_byte) begin
         lane_en   = 4'b0001 << alu_q[1:0];
         lane_data = {4{store_q[7:0]}};
      end else if (is_half) begin
         lane_en   = alu_q[1] ? 4'b1100 : 4'b0011;
         lane_data = {2{store_q[15:0]}};
      end else begin
         lane_en   = 4'b1111;
         lane_data = store_q;
      end
   end

   // Commits at the edge ending the cycle the store sits in MEM; an async reset
   // clears mem_write_q first, so an interrupted store never lands.
   always_ff @(posedge Clock) begin
      if (mem_write_q && !misaligned) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      byte_val = 8'h00;
      case (alu_q[1:0])
         2'b00:   byte_val = mem_word[7:0];
         2'b01:   byte_val = mem_word[15:8];
         2'b10:   byte_val = mem_word[23:16];
         default: byte_val = mem_word[31:24];
      endcase
      half_val = alu_q[1] ? mem_word[31:16] : mem_word[15:0];

      load_val = mem_word;
      if (is_byte) begin
         load_val = unsigned_q ? {24'h000000, byte_val} : {{24{byte_val[7]}}, byte_val};
      end else if (is_half) begin
         load_val = unsigned_q ? {16'h0000, half_val} : {{16{half_val[15]}}, half_val};
      end

      if (!mem_read_q || misaligned) begin
         load_val = '0;
      end
   end

   assign MEM_ALUResult  = alu_q;
   assign MEM_ReadData   = load_val;
   assign MEM_RegDest    = dest_q;
   assign MEM_RegWrite   = reg_write_q && !(mem_read_q && misaligned);
   assign MEM_MemRead    = mem_read_q;
   assign MEM_Misaligned = misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage

module tb_mem_stage;

   logic        Clock;
   logic        Reset;
   logic        Stall;
   logic        Flush;
   logic [31:0] EX_ALUResult;
   logic [31:0] EX_StoreData;
   logic [4:0]  EX_RegDest;
   logic        EX_RegWrite;
   logic        EX_MemRead;
   logic        EX_MemWrite;
   logic [1:0]  EX_MemSize;
   logic        EX_LoadUnsigned;
   logic [31:0] MEM_ALUResult;
   logic [31:0] MEM_ReadData;
   logic [4:0]  MEM_RegDest;
   logic        MEM_RegWrite;
   logic        MEM_MemRead;
   logic        MEM_Misaligned;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        rw;
      logic        mr;
      logic        mis;
      logic [31:0] alu;
      logic [4:0]  dest;
   } exp_t;

   exp_t sb[$];

   localparam logic [1:0] SZ_W = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_B = 2'b10;

   mem_stage #(.ADDR_W(8)) dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .Stall           (Stall),
      .Flush           (Flush),
      .EX_ALUResult    (EX_ALUResult),
      .EX_StoreData    (EX_StoreData),
      .EX_RegDest      (EX_RegDest),
      .EX_RegWrite     (EX_RegWrite),
      .EX_MemRead      (EX_MemRead),
      .EX_MemWrite     (EX_MemWrite),
      .EX_MemSize      (EX_MemSize),
      .EX_LoadUnsigned (EX_LoadUnsigned),
      .MEM_ALUResult   (MEM_ALUResult),
      .MEM_ReadData    (MEM_ReadData),
      .MEM_RegDest     (MEM_RegDest),
      .MEM_RegWrite    (MEM_RegWrite),
      .MEM_MemRead     (MEM_MemRead),
      .MEM_Misaligned  (MEM_Misaligned)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ex(input logic [31:0] a, input logic [31:0] s, input logic [4:0] d,
                     input logic rw, input logic mr, input logic mw,
                     input logic [1:0] sz, input logic lu);
      EX_ALUResult    = a;
      EX_StoreData    = s;
      EX_RegDest      = d;
      EX_RegWrite     = rw;
      EX_MemRead      = mr;
      EX_MemWrite     = mw;
      EX_MemSize      = sz;
      EX_LoadUnsigned = lu;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] rdata, input logic rw,
                             input logic mr, input logic mis, input logic [31:0] alu,
                             input logic [4:0] dest);
      exp_t e;
      e.tag   = tag;
      e.rdata = rdata;
      e.rw    = rw;
      e.mr    = mr;
      e.mis   = mis;
      e.alu   = alu;
      e.dest  = dest;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({e.tag, "_rdata"}, MEM_ReadData, e.rdata);
         chk({e.tag, "_rw"},    {31'd0, MEM_RegWrite}, {31'd0, e.rw});
         chk({e.tag, "_mr"},    {31'd0, MEM_MemRead}, {31'd0, e.mr});
         chk({e.tag, "_mis"},   {31'd0, MEM_Misaligned}, {31'd0, e.mis});
         chk({e.tag, "_alu"},   MEM_ALUResult, e.alu);
         chk({e.tag, "_dest"},  {27'd0, MEM_RegDest}, {27'd0, e.dest});
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      Reset = 1'b0;
      Stall = 1'b0;
      Flush = 1'b0;
      ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, SZ_W, 1'b0);
      #12;
      expect_out("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
      check_out();
      Reset = 1'b1;

      // Store word then load it back the next cycle
      ex(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, SZ_W, 1'b0);
      expect_out("sw_10", 32'h0, 1'b0, 1'b0, 1'b0, 32'h10, 5'd0);
      step(); check_out();
      ex(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, SZ_W, 1'b0);
      expect_out("lw_10", 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h10, 5'd5);
      step(); check_out();

      // Store byte 0x80 into lane 3 of word 4
      ex(32'h13, 32'h12345680, 5'd0, 1'b0, 1'b0, 1'b1, SZ_B, 1'b0);
      expect_out("sb_13", 32'h0, 1'b0, 1'b0, 1'b0, 32'h13, 5'd0);
      step(); check_out();
      ex(32'h13, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, SZ_B, 1'b0);
      expect_out("lb_13", 32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 32'h13, 5'd6);
      step(); check_out();
      ex(32'h13, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, SZ_B, 1'b1);
      expect_out("lbu_13", 32'h00000080, 1'b1, 1'b1, 1'b0, 32'h13, 5'd6);
      step(); check_out();
      ex(32'h10, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, SZ_W, 1'b0);
      expect_out("lw_10_b", 32'h80ADBEEF, 1'b1, 1'b1, 1'b0, 32'h10, 5'd6);
      step(); check_out();

      // Misaligned half load and misaligned word store
      ex(32'h11, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, SZ_H, 1'b0);
      expect_out("lh_11_mis", 32'h0, 1'b0, 1'b1, 1'b1, 32'h11, 5'd8);
      step(); check_out();
      ex(32'h12, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b1, SZ_W, 1'b0);
      expect_out("sw_12_mis", 32'h0, 1'b0, 1'b0, 1'b1, 32'h12, 5'd0);
      step(); check_out();
      ex(32'h10, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, SZ_W, 1'b0);
      expect_out("lw_10_keep", 32'h80ADBEEF, 1'b1, 1'b1, 1'b0, 32'h10, 5'd3);
      step(); check_out();

      // Half loads on both halves, signed and unsigned
      ex(32'h12, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, SZ_H, 1'b0);
      expect_out("lh_12", 32'hFFFF80AD, 1'b1, 1'b1, 1'b0, 32'h12, 5'd4);
      step(); check_out();
      ex(32'h10, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, SZ_H, 1'b1);
      expect_out("lhu_10", 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 32'h10, 5'd7);
      step(); check_out();

      // Stall for three cycles with different EX inputs: outputs hold
      Stall = 1'b1;
      ex(32'h20, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, SZ_W, 1'b0);
      for (int i = 0; i < 3; i++) begin
         expect_out("stall_hold", 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 32'h10, 5'd7);
         step(); check_out();
      end
      Flush = 1'b1;
      expect_out("stall_flush", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
      step(); check_out();
      Stall = 1'b0;
      Flush = 1'b0;

      // Address 0x410 aliases to word 4
      ex(32'h410, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, SZ_W, 1'b0);
      expect_out("sw_410", 32'h0, 1'b0, 1'b0, 1'b0, 32'h410, 5'd0);
      step(); check_out();
      ex(32'h10, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, SZ_W, 1'b0);
      expect_out("lw_alias", 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 32'h10, 5'd2);
      step(); check_out();

      // Reset between latching a store and its commit edge
      ex(32'h10, 32'h55555555, 5'd1, 1'b1, 1'b0, 1'b1, SZ_W, 1'b0);
      expect_out("sw_pre_reset", 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 5'd1);
      step(); check_out();
      Reset = 1'b0;
      #1;
      expect_out("reset_mid", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
      check_out();
      ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, SZ_W, 1'b0);
      step();
      #1;
      Reset = 1'b1;
      ex(32'h10, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, SZ_W, 1'b0);
      expect_out("lw_after_reset", 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 32'h10, 5'd11);
      step(); check_out();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
